local_bias_seq: RTL

Digital power-up sequencer and analog-test-bus router for a multi-channel local bias generator. It brings up the cascode bias first, then enables each requested current branch in index order with a programmable settle interval. It watches pre-synchronised supply comparators and forces a safe shutdown on a sustained supply fault. It sits between the block-level power-down control (`pdb`) and the analog bias cells, replacing direct static wiring of `pdb` and `atb_ena` into the bias macro.

---
 rtl/local_bias_seq_if.sv | 30 +++
 rtl/local_bias_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/local_bias_seq_if.sv
// Control/status bundle between block power control, test-bus control and the local bias sequencer.
// Latency: n/a (wiring only); no backpressure, all signals level-sensitive.
interface local_bias_seq_if #(
  parameter int N_CH = 4
);
  localparam int SW = $clog2(N_CH + 1);

  logic            pdb;
  logic [2:0]      supply_ok;
  logic [N_CH-1:0] ch_en;
  logic [1:0]      atb_ena;
  logic [SW-1:0]   atb_ch;
  logic            vcas_en;
  logic [N_CH-1:0] bias_en;
  logic [N_CH:0]   atb1_sel;
  logic [N_CH:0]   atb0_sel;
  logic            ready;
  logic            fault;
  logic [2:0]      state;

  modport master (
    output pdb, supply_ok, ch_en, atb_ena, atb_ch,
    input  vcas_en, bias_en, atb1_sel, atb0_sel, ready, fault, state
  );

  modport slave (
    input  pdb, supply_ok, ch_en, atb_ena, atb_ch,
    output vcas_en, bias_en, atb1_sel, atb0_sel, ready, fault, state
  );
endinterface

// File: rtl/local_bias_seq.sv
// Power-up sequencer (vcas, then requested branches in index order) with supply-fault shutdown and ATB routing.
// Latency: every output registered, 1 cycle from the deciding input; no backpressure, pdb low wins over everything but rst.
module local_bias_seq #(
  parameter int N_CH       = 4,
  parameter int SETTLE_CYC = 16,
  parameter int FAULT_FILT = 4
) (
  input logic              clk,
  input logic              rst,
  local_bias_seq_if.slave  bus
);

  localparam int IW = $clog2(N_CH + 1);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int FW = $clog2(FAULT_FILT + 1);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    VCAS_UP = 3'd1,
    CH_UP   = 3'd2,
    READY   = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [FW-1:0]   filt_q, filt_d;
  logic            vcas_q, vcas_d;
  logic [N_CH-1:0] bias_q, bias_d;
  logic [N_CH:0]   atb1_q, atb1_d;
  logic [N_CH:0]   atb0_q, atb0_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;

  logic            cur_en;
  logic            settled;
  logic            supply_bad;
  logic            atb_live;
  logic [IW-1:0]   nxt_idx;
  logic [FW-1:0]   filt_inc;
  logic [N_CH:0]   route;

  // Selecting by comparison keeps the out-of-range atb_ch values (> N_CH) mapping to no route.
  always_comb begin
    route = '0;
    for (int i = 0; i <= N_CH; i++) begin
      if (bus.atb_ch == IW'(i)) route[i] = 1'b1;
    end
  end

  always_comb begin
    cur_en = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == IW'(i)) cur_en = mask_q[i];
    end
  end

  assign settled    = (cnt_q == CW'(SETTLE_CYC - 1));
  assign supply_bad = (bus.supply_ok != 3'b111);
  assign nxt_idx    = idx_q + IW'(1);
  assign filt_inc   = filt_q + FW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    bias_d  = bias_q;
    filt_d  = '0;

    case (state_q)
      OFF: begin
        if (bus.pdb) begin
          state_d = VCAS_UP;
          cnt_d   = '0;
        end
      end
      VCAS_UP: begin
        if (settled) begin
          state_d   = CH_UP;
          cnt_d     = '0;
          idx_d     = '0;
          mask_d    = bus.ch_en;
          bias_d    = '0;
          bias_d[0] = bus.ch_en[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CH_UP: begin
        // A masked channel advances on its first cycle; an enabled one waits out its settle time.
        if (!cur_en || settled) begin
          cnt_d = '0;
          idx_d = nxt_idx;
          if (nxt_idx == IW'(N_CH)) begin
            state_d = READY;
          end else begin
            for (int i = 0; i < N_CH; i++) begin
              if (nxt_idx == IW'(i) && mask_q[i]) bias_d[i] = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READY: begin
      end
      FAULT: begin
      end
      default: state_d = OFF;
    endcase

    if (state_q == VCAS_UP || state_q == CH_UP || state_q == READY) begin
      if (supply_bad) begin
        filt_d = filt_inc;
        if (filt_inc == FW'(FAULT_FILT)) state_d = FAULT;
      end
    end

    if (!bus.pdb) state_d = OFF;

    if (state_d == OFF || state_d == FAULT) begin
      cnt_d  = '0;
      idx_d  = '0;
      mask_d = '0;
      bias_d = '0;
      filt_d = '0;
    end
  end

  // Routes only follow the request once READY has been held for a full cycle.
  assign atb_live = (state_q == READY) && (state_d == READY);

  always_comb begin
    vcas_d  = (state_d == VCAS_UP) || (state_d == CH_UP) || (state_d == READY);
    ready_d = (state_d == READY);
    fault_d = (state_d == FAULT);
    atb1_d  = (atb_live && bus.atb_ena[1]) ? route : '0;
    atb0_d  = (atb_live && bus.atb_ena[0]) ? route : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      filt_q  <= '0;
      vcas_q  <= 1'b0;
      bias_q  <= '0;
      atb1_q  <= '0;
      atb0_q  <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      filt_q  <= filt_d;
      vcas_q  <= vcas_d;
      bias_q  <= bias_d;
      atb1_q  <= atb1_d;
      atb0_q  <= atb0_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign bus.vcas_en  = vcas_q;
  assign bus.bias_en  = bias_q;
  assign bus.atb1_sel = atb1_q;
  assign bus.atb0_sel = atb0_q;
  assign bus.ready    = ready_q;
  assign bus.fault    = fault_q;
  assign bus.state    = state_q;

endmodule
